ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver, the next generation of our keyboard input path. Filters and synchronises the raw PS/2 lines, checks the full 11-bit frame (start, 8 data LSB first, odd parity, stop), and runs an inactivity watchdog. Folds E0/F0 prefixes into flag bits on each scan code. Completed codes are buffered in a first-word-fall-through FIFO for the downstream note/key logic.

## Interface
- FILTER_LEN, 4: consecutive equal samples required before the filtered ps2c changes (1..15).
- TIMEOUT_CYC, 50000: clk cycles without a bit event that abort a frame in progress (≥ 2).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ps2c  in  1  raw PS/2 clock, asynchronous.
- ps2d  in  1  raw PS/2 data, asynchronous.
- rd_en  in  1  pop head word; ignored while empty.
- dout  out  10  head word {ext, brk, code[7:0]}; valid while !empty.
- empty  out  1  FIFO empty.
- count  out  FIFO_AW+1  number of stored words.
- err_parity  out  1  one-cycle pulse: parity mismatch, frame discarded.
- err_frame  out  1  one-cycle pulse: stop bit 0 or watchdog timeout, frame discarded.
- overflow  out  1  one-cycle pulse: code dropped because FIFO full.

## Operation
- Input path: ps2c and ps2d each pass through a 2-flop synchroniser. Filtered clock fc resets to 1. fc takes the synchronised ps2c value only after FILTER_LEN consecutive identical samples differing from fc. Bit event ev = fc falling. Data is sampled from synchronised ps2d on ev.
- FSM states: IDLE, DATA, PARITY, STOP. bit counter 0..7 and shift register are internal.
  - IDLE: ev with d=0 → DATA, counter=0. ev with d=1 → stay IDLE, no error.
  - DATA: on each ev, shift d into code[counter]. After the 8th bit → PARITY.
  - PARITY: on ev, latch parity_ok = (^code ^ d) == 1 → STOP.
  - STOP: on ev → IDLE.
    - d=0: err_frame.
    - d=1 and !parity_ok: err_parity.
    - Otherwise: byte accepted.
- Watchdog: counter clears on every ev and while in IDLE. In DATA/PARITY/STOP, reaching TIMEOUT_CYC → IDLE, err_frame pulse, counter clears.
- Prefix folding on accepted byte:
  - E0: set ext.
  - F0: set brk.
  - Neither flag-byte pushes anything.
  - Any other byte pushes {ext, brk, byte}, then clears ext and brk.
  - Any error also clears ext and brk.
- FIFO: depth 2**FIFO_AW. Pointers wrap modulo depth. count distinguishes full (count = depth) from empty.
  - Push while full: drop the word, pulse overflow, FIFO unchanged.
  - Simultaneous push and pop:
    - Non-empty and non-full: both performed, count unchanged.
    - Full: pop frees a slot, so the push is accepted and there is no overflow.
    - Empty: the pop is ignored and the push is accepted.
- Reset values: empty=1, count=0, dout=0, all error pulses 0. Internal: fc=1, state IDLE, ext=brk=0, pointers 0.
  - Reset mid-frame discards the partial frame.
  - The first frame after reset release is received normally if its start edge follows the release.

## Timing
- ev is asserted 2+FILTER_LEN clk cycles after the first clk edge that samples raw ps2c low, given stable low.
- Low pulses shorter than FILTER_LEN samples produce no ev.
- Stop-bit ev in cycle E: push, error pulses and overflow occur at the edge ending E and are visible in cycle E+1. empty falls and count increments in E+1.
- dout is first-word-fall-through: it shows the head word combinationally from RAM/registers whenever !empty. rd_en high at an edge advances the head; the next word appears in the following cycle.
- All outputs change only on clk edges, except through asynchronous reset.
- PS/2 bit period (≥ 60 µs) far exceeds pipeline latency; the block accepts back-to-back frames with no gap requirement beyond the stop bit.

## Test plan
- Make code 1C, parity 0 → dout=0x01C, count=1. rd_en one cycle → empty=1.
- F0 (parity 1) then 1C; E0 (parity 0), F0, 75 (parity 0) → FIFO holds 0x11C then 0x375, count=2, no error pulses.
- Frame 1C with parity bit 1 → single err_parity pulse, count stays 0. Following F0 1C yields 0x11C, proving the flags are cleared.
- Stop clocking after 4 data bits, wait TIMEOUT_CYC → err_frame pulse, state IDLE. Next clean 1C frame → 0x01C.
- FIFO_AW=2: send 5 codes 16,1E,26,25,2E without reading → count=4 and one overflow pulse on the 5th. Reads return 016,01E,026,025 in order. Push coinciding with rd_en while full → no overflow.
- FILTER_LEN=4: 2-cycle low glitch on ps2c in IDLE → no ev, no state change. Assert rst mid-DATA → outputs at reset values, next frame received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame check with
// an inactivity watchdog, E0/F0 prefix folding, and a first-word-fall-through code FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_AW     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2c,
    input  logic             ps2d,
    input  logic             rd_en,
    output logic [9:0]       dout,
    output logic             empty,
    output logic [FIFO_AW:0] count,
    output logic             err_parity,
    output logic             err_frame,
    output logic             overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int WW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock filter
    // ------------------------------------------------------------------
    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_s;
    logic          d_s;
    logic [FW-1:0] flt_cnt;
    logic          fc;
    logic          fc_prev;
    logic          ev;

    assign c_s = c_sync[1];
    assign d_s = d_sync[1];

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the second synchroniser stage would collapse into the first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // fc only moves after FILTER_LEN consecutive samples that disagree with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_cnt <= '0;
            fc      <= 1'b1;
            fc_prev <= 1'b1;
        end else begin
            fc_prev <= fc;
            if (c_s == fc) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                fc      <= c_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign ev = fc_prev & ~fc;

    // ------------------------------------------------------------------
    // Frame FSM, watchdog and prefix folding
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    code;
    logic [7:0]    code_nxt;
    logic          parity_ok;
    logic          par_nxt;
    logic [WW-1:0] wd_cnt;
    logic [WW-1:0] wd_nxt;
    logic          ext;
    logic          ext_nxt;
    logic          brk;
    logic          brk_nxt;
    logic          perr_nxt;
    logic          ferr_nxt;
    logic          timeout;
    logic          push;
    logic [9:0]    push_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            code       <= '0;
            parity_ok  <= 1'b0;
            wd_cnt     <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            code       <= code_nxt;
            parity_ok  <= par_nxt;
            wd_cnt     <= wd_nxt;
            ext        <= ext_nxt;
            brk        <= brk_nxt;
            err_parity <= perr_nxt;
            err_frame  <= ferr_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        code_nxt  = code;
        par_nxt   = parity_ok;
        ext_nxt   = ext;
        brk_nxt   = brk;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        push      = 1'b0;
        push_word = {ext, brk, code};
        wd_nxt    = (ev || state == IDLE) ? '0 : wd_cnt + WW'(1);
        timeout   = (state != IDLE) && !ev && (wd_cnt == WW'(TIMEOUT_CYC - 1));

        if (timeout) begin
            state_nxt = IDLE;
            ferr_nxt  = 1'b1;
            ext_nxt   = 1'b0;
            brk_nxt   = 1'b0;
            wd_nxt    = '0;
        end else if (ev) begin
            case (state)
                IDLE: begin
                    if (!d_s) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
                DATA: begin
                    code_nxt[bit_cnt] = d_s;
                    bit_nxt           = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = ^code ^ d_s;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!d_s) begin
                        ferr_nxt = 1'b1;
                        ext_nxt  = 1'b0;
                        brk_nxt  = 1'b0;
                    end else if (!parity_ok) begin
                        perr_nxt = 1'b1;
                        ext_nxt  = 1'b0;
                        brk_nxt  = 1'b0;
                    end else if (code == 8'hE0) begin
                        ext_nxt = 1'b1;
                    end else if (code == 8'hF0) begin
                        brk_nxt = 1'b1;
                    end else begin
                        push    = 1'b1;
                        ext_nxt = 1'b0;
                        brk_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               full;
    logic               do_pop;
    logic               do_push;

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; count/empty gate every read,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames, models prefix folding and
// the FIFO with a scoreboard queue, and checks outputs with immediate assertions.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 300;
    localparam int FIFO_AW     = 2;
    localparam int DEPTH       = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ps2c = 1'b1;
    logic             ps2d = 1'b1;
    logic             rd_en = 1'b0;
    logic [9:0]       dout;
    logic             empty;
    logic [FIFO_AW:0] count;
    logic             err_parity;
    logic             err_frame;
    logic             overflow;

    ps2_rx_fifo #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .count     (count),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] sb[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0;

    always @(negedge clk) begin
        if (err_parity) n_par++;
        if (err_frame)  n_frm++;
        if (overflow)   n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit; with pop set, rd_en is high exactly at the edge that acts on the bit event.
    task automatic send_bit(input logic b, input bit pop);
        ps2d = b;
        tick(5);
        ps2c = 1'b0;
        if (pop) begin
            tick(FILTER_LEN + 2);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(20 - FILTER_LEN - 3);
        end else begin
            tick(20);
        end
        ps2c = 1'b1;
        tick(15);
    endtask

    task automatic status(input string tag);
        check({tag, "_count"}, 32'(count), 32'(sb.size()));
        check({tag, "_perr"},  32'(n_par), 32'(exp_par));
        check({tag, "_ferr"},  32'(n_frm), 32'(exp_frm));
        check({tag, "_ovf"},   32'(n_ovf), 32'(exp_ovf));
        if (sb.size() != 0) check({tag, "_head"}, 32'(dout), 32'(sb[0]));
        else                check({tag, "_empty"}, 32'(empty), 32'd1);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b,
                              input bit bad_par, input bit bad_stop, input bit pop);
        logic [9:0] popped;
        if (pop) begin
            check({tag, "_prepop"}, 32'(dout), 32'(sb[0]));
            popped = sb.pop_front();
        end
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit((~^b) ^ bad_par, 1'b0);
        send_bit(~bad_stop, pop);
        if (bad_stop) begin
            exp_frm++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (bad_par) begin
            exp_par++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (sb.size() < DEPTH) sb.push_back({m_ext, m_brk, b});
            else                   exp_ovf++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        status(tag);
    endtask

    task automatic send_good(input string tag, input logic [7:0] b);
        send_frame(tag, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_partial(input int ndata);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < ndata; i++) send_bit(i[0], 1'b0);
    endtask

    task automatic read_word(input string tag);
        logic [9:0] w;
        check({tag, "_rd_empty"}, 32'(empty), 32'd0);
        check({tag, "_rd_dout"},  32'(dout),  32'(sb[0]));
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        w = sb.pop_front();
        check({tag, "_rd_count"}, 32'(count), 32'(sb.size()));
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // reset state
        tick(3);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_pulses", 32'({err_parity, err_frame, overflow}), 32'd0);
        rst = 1'b1;
        tick(5);

        // plain make code
        send_good("mk1c", 8'h1C);
        check("mk1c_value", 32'(dout), 32'h01C);
        read_word("mk1c");
        check("mk1c_empty_after", 32'(empty), 32'd1);

        // break and extended-break sequences
        send_good("f0", 8'hF0);
        send_good("f0_1c", 8'h1C);
        send_good("e0", 8'hE0);
        send_good("e0_f0", 8'hF0);
        send_good("e0_f0_75", 8'h75);
        check("fold_head", 32'(dout), 32'h11C);
        read_word("fold1");
        check("fold_second", 32'(dout), 32'h375);
        read_word("fold2");

        // parity error clears flags; stop-bit error reported as frame error
        send_good("pe_e0", 8'hE0);
        send_frame("pe_bad", 8'h1C, 1'b1, 1'b0, 1'b0);
        send_good("pe_f0", 8'hF0);
        send_good("pe_1c", 8'h1C);
        read_word("pe");
        send_frame("stop_bad", 8'h1C, 1'b0, 1'b1, 1'b0);

        // watchdog abort mid-frame
        send_good("wd_f0", 8'hF0);
        send_partial(4);
        tick(TIMEOUT_CYC + 20);
        exp_frm++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        status("wd_abort");
        send_good("wd_1c", 8'h1C);
        read_word("wd");

        // overflow on the fifth code
        send_good("ov16", 8'h16);
        send_good("ov1e", 8'h1E);
        send_good("ov26", 8'h26);
        send_good("ov25", 8'h25);
        send_good("ov2e", 8'h2E);
        check("ov_count_full", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) read_word("ov_drain");

        // push coinciding with a pop while full: accepted, no overflow
        send_good("fp16", 8'h16);
        send_good("fp1e", 8'h1E);
        send_good("fp26", 8'h26);
        send_good("fp25", 8'h25);
        send_frame("fp2e_pop", 8'h2E, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) read_word("fp_drain");

        // short low glitch on ps2c while ps2d is low: no bit event
        ps2d = 1'b0;
        tick(5);
        ps2c = 1'b0;
        tick(2);
        ps2c = 1'b1;
        tick(20);
        status("glitch");
        send_good("glitch_1c", 8'h1C);
        read_word("glitch");

        // reset in the middle of a frame
        send_good("rm_1c", 8'h1C);
        send_good("rm_e0", 8'hE0);
        send_partial(3);
        rst = 1'b0;
        tick(2);
        check("rm_empty", 32'(empty), 32'd1);
        check("rm_count", 32'(count), 32'd0);
        check("rm_dout",  32'(dout),  32'd0);
        check("rm_pulses", 32'({err_parity, err_frame, overflow}), 32'd0);
        sb.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(5);
        send_good("rm_after", 8'h1C);
        check("rm_after_value", 32'(dout), 32'h01C);
        read_word("rm");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
